// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU producing {HI, LO} = {remainder, quotient}.
// Build option: define DIV_ZERO_FAST_EN to finish divide-by-zero in one cycle instead of WIDTH steps.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic               a_neg, b_neg, b_zero, last_step;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [WIDTH:0]     shifted, trial;

  assign a_neg     = signed_div & a[WIDTH-1];
  assign b_neg     = signed_div & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign b_zero    = (b == '0);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  // rem < divisor always holds, so WIDTH+1 bits is enough for the trial sign
  assign shifted   = {rem_q, quo_q[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign quo_fix   = qneg_q ? -quo_q : quo_q;
  assign rem_fix   = rneg_q ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (annul) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
`ifdef DIV_ZERO_FAST_EN
            state_d = b_zero ? DONE : BUSY;
`else
            state_d = BUSY;
`endif
          end
        end
        BUSY:    if (last_step) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Result is shown directly in the ready cycle so HI/LO can be written alongside ready
  always_comb begin
    ready  = (state_q == DONE);
    stall  = start & ~ready;
    result = ready ? {rem_fix, quo_fix} : res_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    res_d  = res_q;
    if (annul) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvs_d  = b_mag;
            rem_d  = '0;
            quo_d  = a_mag;
            qneg_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d = a_neg;
            cnt_d  = '0;
`ifdef DIV_ZERO_FAST_EN
            if (b_zero) begin
              rem_d = a_mag;
              quo_d = '1;
            end
`endif
          end
        end
        BUSY: begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
        DONE:    res_d = {rem_fix, quo_fix};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      res_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      res_q  <= res_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit; latency counts rising edges from the sampling edge inclusive.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int errors = 0;
  int checks = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .a(a), .b(b), .result(result), .ready(ready), .stall(stall)
  );

  always #5 clk = ~clk;

  // Drives one division (called 1ns after a rising edge) and measures it; no checking here.
  task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         input bit scramble, input bit annul_at_ready,
                         output int lat, output logic [63:0] res, output bit stall_ok,
                         output logic rdy_after, output logic [63:0] res_after);
    a = av; b = bv; signed_div = sv; start = 1'b1;
    #1;
    stall_ok = (stall === 1'b1);
    #0;
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (ready === 1'b1 || lat > 200) break;
      if (stall !== 1'b1) stall_ok = 0;
      if (scramble && lat == 5) begin
        a = 32'hDEAD_BEEF; b = 32'h0000_0003; signed_div = ~sv;
      end
    end
    res = result;
    if (stall !== 1'b0) stall_ok = 0;
    if (annul_at_ready) annul = 1'b1;
    @(posedge clk); #1;
    rdy_after = ready;
    res_after = result;
    start = 1'b0; annul = 1'b0; a = '0; b = '0; signed_div = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_lo got=%b exp=0", stall); end
    start = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_hi got=%b exp=1", stall); end
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    int lat; logic [63:0] res, res2; bit sok; logic r2;
    run_div(32'd100, 32'd7, 1'b0, 1'b1, 1'b0, lat, res, sok, r2, res2);
    checks++; if (lat !== 33) begin errors++; $display("FAIL udiv_latency got=%0d exp=33", lat); end
    checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL udiv_result got=%h exp=%h", res, {32'd2, 32'd14}); end
    checks++; if (sok !== 1'b1) begin errors++; $display("FAIL udiv_stall got=%b exp=1", sok); end
    checks++; if (r2 !== 1'b0) begin errors++; $display("FAIL udiv_ready_pulse got=%b exp=0", r2); end
    checks++; if (res2 !== {32'd2, 32'd14}) begin errors++; $display("FAIL udiv_hold got=%h exp=%h", res2, {32'd2, 32'd14}); end
  endtask

  task automatic test_signed;
    int lat; logic [63:0] res, res2; bit sok; logic r2;
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0, lat, res, sok, r2, res2);
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL sdiv_neg_a got=%h exp=ffffffff_fffffffd", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL sdiv_latency got=%0d exp=33", lat); end
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, lat, res, sok, r2, res2);
    checks++; if (res !== 64'h0000_0001_FFFF_FFFD) begin errors++; $display("FAIL sdiv_neg_b got=%h exp=00000001_fffffffd", res); end
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, lat, res, sok, r2, res2);
    checks++; if (res !== {32'd1, 32'h7FFF_FFFC}) begin errors++; $display("FAIL udiv_big got=%h exp=00000001_7ffffffc", res); end
  endtask

  task automatic test_overflow;
    int lat; logic [63:0] res, res2; bit sok; logic r2;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, lat, res, sok, r2, res2);
    checks++; if (res !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL ovf_result got=%h exp=00000000_80000000", res); end
    checks++; if ((^{res2, r2, stall}) === 1'bx) begin errors++; $display("FAIL ovf_no_x got=%h exp=known", res2); end
  endtask

  task automatic test_div_zero;
    int lat; logic [63:0] res, res2; bit sok; logic r2;
    run_div(32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0, lat, res, sok, r2, res2);
    checks++; if (res !== 64'h1234_5678_FFFF_FFFF) begin errors++; $display("FAIL dz_u_result got=%h exp=12345678_ffffffff", res); end
    checks++; if (lat !== ZLAT) begin errors++; $display("FAIL dz_u_latency got=%0d exp=%0d", lat, ZLAT); end
    run_div(32'hFFFF_FFF8, 32'd0, 1'b1, 1'b0, 1'b0, lat, res, sok, r2, res2);
    checks++; if (res !== 64'hFFFF_FFF8_0000_0001) begin errors++; $display("FAIL dz_s_result got=%h exp=fffffff8_00000001", res); end
    checks++; if (lat !== ZLAT) begin errors++; $display("FAIL dz_s_latency got=%0d exp=%0d", lat, ZLAT); end
  endtask

  task automatic test_annul;
    int lat, seen; logic [63:0] res, res2, prev; bit sok; logic r2;
    prev = result;
    a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL annul_ready got=%b exp=0", ready); end
    checks++; if (result !== prev) begin errors++; $display("FAIL annul_hold got=%h exp=%h", result, prev); end
    @(posedge clk); #1;
    run_div(32'd50, 32'd5, 1'b0, 1'b0, 1'b0, lat, res, sok, r2, res2);
    checks++; if (res !== {32'd0, 32'd10}) begin errors++; $display("FAIL annul_restart got=%h exp=%h", res, {32'd0, 32'd10}); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL annul_restart_lat got=%0d exp=33", lat); end
    // annul and start together in IDLE: nothing may start
    a = 32'd9; b = 32'd3; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ready === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL annul_beats_start got=%0d exp=0", seen); end
    prev = result;
    run_div(32'd9, 32'd2, 1'b0, 1'b0, 1'b1, lat, res, sok, r2, res2);
    checks++; if (res2 !== prev) begin errors++; $display("FAIL annul_in_done got=%h exp=%h", res2, prev); end
  endtask

  task automatic test_reset_busy;
    int lat; logic [63:0] res, res2; bit sok; logic r2;
    a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_busy_ready got=%b exp=0", ready); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL rst_busy_result got=%h exp=0", result); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_busy_stall got=%b exp=1", stall); end
    @(posedge clk); #1;
    rst = 1'b1;
    run_div(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, lat, res, sok, r2, res2);
    checks++; if (res !== {32'd1, 32'd333}) begin errors++; $display("FAIL rst_resume got=%h exp=%h", res, {32'd1, 32'd333}); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL rst_resume_lat got=%0d exp=33", lat); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [63:0] res, res2; bit sok; logic r2;
    run_div(32'd1000, 32'd10, 1'b0, 1'b0, 1'b0, lat, res, sok, r2, res2);
    checks++; if (res !== {32'd0, 32'd100}) begin errors++; $display("FAIL b2b_first got=%h exp=%h", res, {32'd0, 32'd100}); end
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, lat, res, sok, r2, res2);
    checks++; if (res !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL b2b_second got=%h exp=00000000_ffffffff", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    #1;
    test_reset;
    test_unsigned;
    test_signed;
    test_overflow;
    test_div_zero;
    test_annul;
    test_reset_busy;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
